// File: rtl/onewire_pkg.sv
// Shared definitions for the onewire byte sequencer: opcodes, status/control
// bit positions, FSM encoding and the transmitted-bit helper.
package onewire_pkg;

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam int ST_DONE = 4;
  localparam int ST_DAT  = 0;
  localparam int CT_RST  = 1;
  localparam int CT_DAT  = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_POLL  = 3'd2,
    S_GAP   = 3'd3,
    S_NEXT  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  // Read slots are started by releasing the line, i.e. sending a 1.
  function automatic logic tx_bit(input logic [1:0] op, input logic [7:0] data,
                                  input logic [2:0] idx);
    return (op == OP_RD) ? 1'b1 : data[idx];
  endfunction

endpackage

// File: rtl/onewire_avm_port.sv
// Single-outstanding Avalon-MM request holder: a start pulse raises the request,
// it is held until waitrequest drops, then done pulses with the captured status.
module onewire_avm_port
  import onewire_pkg::*;
#(
  parameter int ADW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_wr,
  input  logic           start_rd,
  input  logic [ADW-1:0] wdata,
  output logic           avm_read,
  output logic           avm_write,
  output logic [ADW-1:0] avm_writedata,
  input  logic [ADW-1:0] avm_readdata,
  input  logic           avm_waitrequest,
  output logic           done,
  output logic           st_done,
  output logic           st_dat
);

  logic unused_rd;
  assign unused_rd = ^{avm_readdata[ADW-1:ST_DONE+1], avm_readdata[ST_DONE-1:ST_DAT+1]};

  // Request hold, completion pulse and status capture
  always_ff @(posedge clk) begin
    if (rst) begin
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
      done          <= 1'b0;
      st_done       <= 1'b0;
      st_dat        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (avm_read || avm_write) begin
        if (!avm_waitrequest) begin
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
          done      <= 1'b1;
          if (avm_read) begin
            st_done <= avm_readdata[ST_DONE];
            st_dat  <= avm_readdata[ST_DAT];
          end
        end
      end else if (start_wr) begin
        avm_write     <= 1'b1;
        avm_writedata <= wdata;
      end else if (start_rd) begin
        avm_read <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/onewire_byte_seq.sv
// Byte-level command sequencer: turns reset/write/read-byte commands into
// per-bit master cycles on Avalon-MM, polling status until each cycle is done.
module onewire_byte_seq
  import onewire_pkg::*;
#(
  parameter int ADW      = 32,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [7:0]     cmd_data,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [7:0]     rsp_data,
  output logic           rsp_presence,
  output logic           rsp_err,
  output logic           busy,
  output logic           avm_read,
  output logic           avm_write,
  output logic [ADW-1:0] avm_writedata,
  input  logic [ADW-1:0] avm_readdata,
  input  logic           avm_waitrequest
);

  localparam logic [12:0] PMAX  = 13'(POLL_MAX);
  localparam logic [15:0] GLAST = 16'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_t         state;
  logic [1:0]     op_r;
  logic [7:0]     data_r;
  logic [2:0]     bitcnt;
  logic [12:0]    pollcnt;
  logic [15:0]    gapcnt;
  logic           wr_go;
  logic           rd_go;
  logic           done;
  logic           st_done;
  logic           st_dat;
  logic [ADW-1:0] wdata;

  // Control word for the next bit-cycle
  always_comb begin
    wdata         = '0;
    wdata[CT_RST] = (op_r == OP_RST);
    wdata[CT_DAT] = (op_r != OP_RST) & tx_bit(op_r, data_r, bitcnt);
  end

  onewire_avm_port #(.ADW(ADW)) u_port (
    .clk            (clk),
    .rst            (rst),
    .start_wr       (wr_go),
    .start_rd       (rd_go),
    .wdata          (wdata),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .done           (done),
    .st_done        (st_done),
    .st_dat         (st_dat)
  );

  // Command sequencing FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      rsp_presence <= 1'b0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      op_r         <= OP_NOP;
      data_r       <= 8'h00;
      bitcnt       <= 3'd0;
      pollcnt      <= 13'd0;
      gapcnt       <= 16'd0;
      wr_go        <= 1'b0;
      rd_go        <= 1'b0;
    end else begin
      wr_go <= 1'b0;
      rd_go <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            op_r         <= cmd_op;
            data_r       <= cmd_data;
            bitcnt       <= 3'd0;
            pollcnt      <= 13'd0;
            rsp_data     <= 8'h00;
            rsp_presence <= 1'b0;
            rsp_err      <= 1'b0;
            if (cmd_op == OP_NOP) begin
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              wr_go <= 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (done) begin
            rd_go <= 1'b1;
            state <= S_POLL;
          end
        end
        S_POLL: begin
          if (done) begin
            if (st_done) begin
              state <= S_NEXT;
            end else if (pollcnt + 13'd1 >= PMAX) begin
              pollcnt   <= PMAX;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              pollcnt <= pollcnt + 13'd1;
              if (POLL_GAP == 0) begin
                rd_go <= 1'b1;
              end else begin
                gapcnt <= 16'd0;
                state  <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (gapcnt == GLAST) begin
            rd_go <= 1'b1;
            state <= S_POLL;
          end else begin
            gapcnt <= gapcnt + 16'd1;
          end
        end
        S_NEXT: begin
          // A low line during the presence window means a slave answered.
          if (op_r == OP_RST) begin
            rsp_presence <= ~st_dat;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else begin
            if (op_r == OP_RD) rsp_data[bitcnt] <= st_dat;
            if (bitcnt == 3'd7) begin
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              bitcnt  <= bitcnt + 3'd1;
              pollcnt <= 13'd0;
              wr_go   <= 1'b1;
              state   <= S_ISSUE;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
